// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile: header/data command decoder and 16-bit register file fed
// by the SPI slave shifter. A header (sync 4'hA) either reads a register into
// rd_data or arms a write that the next word completes, with a timeout.
// Optional build macro SPI_CMD_ERRCNT_EN adds an 8-bit saturating error
// counter that is readable (and cleared) at address 4'hF.
module spi_cmd_regfile #(
  parameter int NREG    = 8,
  parameter int TIMEOUT = 48000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          word_in,
  input  logic                 word_stb,
  output logic [15:0]          rd_data,
  output logic [16*NREG-1:0]   reg_q,
  output logic                 wr_stb,
  output logic [3:0]           wr_addr,
  output logic                 err,
  output logic                 busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX   = CW'(TIMEOUT - 1);
  localparam logic [4:0]    NREG_W = 5'(NREG);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t        state, state_nxt;
  logic [3:0]    pend_addr, pend_addr_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;
  logic          err_nxt;
  logic          wr_en;
  logic [15:0]   rd_nxt;
  logic [15:0]   rd_sel;
  logic          hdr_sync;
  logic          hdr_wr;
  logic [3:0]    hdr_addr;

  // True when the address maps to an implemented register.
  function automatic logic addr_ok(input logic [3:0] a);
    return ({1'b0, a} < NREG_W);
  endfunction

`ifdef SPI_CMD_ERRCNT_EN
  logic [7:0] errcnt;
  logic       errcnt_clr;

  // Saturating increment, holds at 8'hFF.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign hdr_sync = (word_in[15:12] == 4'hA);
  assign hdr_wr   = word_in[11];
  assign hdr_addr = word_in[3:0];

  // Read mux: select the register addressed by the incoming header.
  always_comb begin
    rd_sel = '0;
    for (int r = 0; r < NREG; r++) begin
      if (hdr_addr == 4'(r)) rd_sel = reg_q[16*r +: 16];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output decode for header/data protocol and timeout.
  always_comb begin
    state_nxt     = state;
    pend_addr_nxt = pend_addr;
    tcnt_nxt      = tcnt;
    err_nxt       = 1'b0;
    wr_en         = 1'b0;
    rd_nxt        = rd_data;
`ifdef SPI_CMD_ERRCNT_EN
    errcnt_clr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (word_stb) begin
          if (!hdr_sync) begin
            err_nxt = 1'b1;
          end else if (hdr_wr) begin
            pend_addr_nxt = hdr_addr;
            tcnt_nxt      = '0;
            state_nxt     = WAIT_DATA;
`ifdef SPI_CMD_ERRCNT_EN
          end else if (hdr_addr == 4'hF) begin
            rd_nxt     = {8'h00, errcnt};
            errcnt_clr = 1'b1;
`endif
          end else if (addr_ok(hdr_addr)) begin
            rd_nxt = rd_sel;
          end else begin
            rd_nxt  = 16'h0000;
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        // A data word in the expiry cycle still wins over the timeout.
        if (word_stb) begin
          if (addr_ok(pend_addr)) wr_en   = 1'b1;
          else                    err_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt == TMAX) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, pending address, timeout counter and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= '0;
      reg_q     <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      pend_addr <= '0;
      tcnt      <= '0;
    end else begin
      rd_data   <= rd_nxt;
      wr_stb    <= wr_en;
      err       <= err_nxt;
      busy      <= (state_nxt == WAIT_DATA);
      pend_addr <= pend_addr_nxt;
      tcnt      <= tcnt_nxt;
      if (wr_en) wr_addr <= pend_addr;
      for (int r = 0; r < NREG; r++) begin
        if (wr_en && pend_addr == 4'(r)) reg_q[16*r +: 16] <= word_in;
      end
    end
  end

`ifdef SPI_CMD_ERRCNT_EN
  // Error counter: counts err pulses, cleared by a read of address 4'hF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          errcnt <= '0;
    else if (errcnt_clr) errcnt <= err ? 8'd1 : 8'd0;
    else if (err)        errcnt <= sat_inc(errcnt);
  end
`endif

endmodule

// File: doc/spi_cmd_regfile.md
# spi_cmd_regfile

Command decoder and register file that consumes the 16-bit words produced by the SPI slave shifter. Each word is presented with a one-cycle strobe at SPI chip-select release. A header/data word protocol writes up to 15 16-bit configuration registers. The block also returns a register value, which the shifter loads into its MISO shift register on the next chip-select assertion. Both blocks sit in the single 48 MHz internal-oscillator domain.

## Interface
Parameters:
- NREG, 8: number of implemented registers, legal range 1..15.
- TIMEOUT, 48000: clk cycles allowed between a write header and its data word (1 ms at 48 MHz), minimum 2.

Ports (one clock, asynchronous active-low reset):
- clk  in  1  system clock, 48 MHz from SB_HFOSC.
- rst_n  in  1  asynchronous active-low reset.
- word_in  in  16  word from the SPI shifter. Valid only when word_stb=1.
- word_stb  in  1  single-cycle pulse, one per received SPI word.
- rd_data  out  16  read-back value for the shifter's next MISO load. Reset 16'h0000.
- reg_q  out  16*NREG  flattened register contents, reg r at [16r+15:16r]. Reset all 0.
- wr_stb  out  1  one-cycle pulse after a register update. Reset 0.
- wr_addr  out  4  address of the last write, valid with wr_stb. Reset 0.
- err  out  1  one-cycle pulse on any protocol error. Reset 0.
- busy  out  1  high while in state WAIT_DATA. Reset 0.

## Operation
Header word format:
- [15:12]: sync nibble, must be 4'hA.
- [11]: W (1 = write, 0 = read).
- [10:4]: reserved, ignored.
- [3:0]: address A.

FSM has two states, IDLE and WAIT_DATA. Reset state is IDLE.
- IDLE, word_stb, bad sync:
  - err pulses.
  - Stay in IDLE.
- IDLE, word_stb, valid read:
  - If A<NREG, rd_data <= reg[A].
  - Otherwise rd_data <= 16'h0000 and err pulses.
  - Stay in IDLE.
- IDLE, word_stb, valid write:
  - Latch A into the pending address.
  - Clear the timeout counter.
  - Go to WAIT_DATA.
- WAIT_DATA, word_stb:
  - If pending A<NREG: reg[A] <= word_in, wr_addr <= A, wr_stb pulses.
  - If pending A>=NREG: the data is discarded and err pulses.
  - Go to IDLE. The data word is never interpreted as a header, even if its upper nibble is 4'hA.
- WAIT_DATA, no word_stb:
  - The timeout counter increments.
  - When the counter reaches TIMEOUT-1: err pulses, go to IDLE, the pending write is dropped.
- Simultaneous word_stb and timeout expiry: word_stb wins and the data is accepted normally.
- rd_data holds its value until the next valid read. Writes do not update rd_data, including writes to the last-read address.
- Timeout counter width is $clog2(TIMEOUT). It never wraps, because expiry forces IDLE.
- Reset asserted mid-transaction:
  - FSM returns to IDLE immediately.
  - Registers and all outputs take their reset values.
  - The pending write is lost.

## Timing
- All outputs are registered.
- Write, with data word_stb at cycle N:
  - reg_q updates at N+1.
  - wr_stb and wr_addr are valid at N+1, for 1 cycle.
  - busy falls at N+1.
- Write header word_stb at cycle N: busy rises at N+1.
- Read header word_stb at cycle N: rd_data is valid at N+1. This is well before the next CS falling edge at any SPI rate below 24 MHz.
- err is always a single cycle, asserted in the cycle after the offending word_stb or timeout expiry.
- Back-to-back word_stb on consecutive cycles is accepted. There is no stall and no input backpressure.

## Configuration
Macro: SPI_CMD_ERRCNT_EN.
- Defined:
  - An 8-bit saturating counter increments on every err pulse and holds at 8'hFF. Reset value is 0.
  - A read of A=4'hF returns {8'h00, errcnt} and is not an error.
  - A read of A=4'hF clears the counter in the same cycle that rd_data is loaded. If an err pulse coincides with this read, the counter is set to 1.
  - A write to A=4'hF is an out-of-range error as usual.
- Undefined: no counter is implemented. A=4'hF behaves like any address >= NREG.

## Test plan
- Reset, then write: send 16'hA803, then 16'h1234. Expect reg[3]=16'h1234, wr_stb for 1 cycle with wr_addr=3, err=0.
- Read: send 16'hA003. Expect rd_data=16'h1234 one cycle after word_stb, FSM stays in IDLE.
- Errors:
  - Send 16'h5803: expect an err pulse and no state change.
  - Send 16'hA80C with NREG=8, then any data word: expect err on the data word and reg_q unchanged.
  - Send 16'hA00C: expect rd_data=0 and an err pulse.
- Timeout: send 16'hA801, then no data for TIMEOUT cycles. Expect err at expiry, busy=0, and a following 16'hA801/16'h00FF pair writes reg[1]=16'h00FF.
- Boundaries:
  - Data word_stb in the exact expiry cycle: data is accepted and err=0.
  - rst_n low while in WAIT_DATA: busy=0, reg_q=0, rd_data=0 immediately.
- SPI_CMD_ERRCNT_EN defined: generate 3 errors, then send 16'hA00F. Expect rd_data=16'h0003 and the counter cleared; a second 16'hA00F returns 16'h0000.
